// File: rtl/esp_storage_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : esp_storage_responder_pkg
// Description : Shared ESP command-word definitions for the storage responder:
//               op codes, init word, FSM state encoding, capture record type
//               and the response op mapping helper.
// Revision    : 1.0 - initial release
// ============================================================================
package esp_storage_responder_pkg;

  // Op codes carried in word bits [26:24]
  localparam logic [2:0] C_OP_INIT  = 3'b000;  // reserved, used only by the init word
  localparam logic [2:0] C_OP_READ  = 3'b001;
  localparam logic [2:0] C_OP_WRITE = 3'b010;
  localparam logic [2:0] C_OP_PING  = 3'b011;
  localparam logic [2:0] C_OP_ERR   = 3'b111;

  // R=1, op=000, data=FF, addr=00, tag=00
  localparam logic [27:0] C_INIT_WORD = 28'h8FF_0000;

  typedef enum logic [2:0] {
    ST_ANNOUNCE = 3'd0,
    ST_ANN_GAP  = 3'd1,
    ST_LISTEN   = 3'd2,
    ST_TURN     = 3'd3,
    ST_RESPOND  = 3'd4
  } esp_state_t;

  // Fields of a captured command needed to build its response
  typedef struct packed {
    logic [2:0] op;
    logic [7:0] addr;
    logic [7:0] tag;
  } esp_cap_t;

  // Unknown ops are answered with the error op
  function automatic logic [2:0] esp_resp_op(input logic [2:0] op);
    case (op)
      C_OP_READ, C_OP_WRITE, C_OP_PING: esp_resp_op = op;
      default:                          esp_resp_op = C_OP_ERR;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/esp_storage_responder_mem.sv
`default_nettype none
// ============================================================================
// Module      : esp_storage_responder_mem
// Description : 256x8 single-port byte store, synchronous read, write-first.
//               Contents are not reset.
// Ports       : clk   - clock
//               en    - access enable (read or write this edge)
//               we    - write enable (qualified by en)
//               addr  - byte address
//               wdata - write byte
//               rdata - registered read byte (write data on a write)
// Revision    : 1.0 - initial release
// ============================================================================
module esp_storage_responder_mem (
  input  logic       clk,
  input  logic       en,
  input  logic       we,
  input  logic [7:0] addr,
  input  logic [7:0] wdata,
  output logic [7:0] rdata
);

  logic [7:0] r_mem [256];
  logic [7:0] r_rdata;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        r_mem[addr] <= wdata;
        r_rdata     <= wdata;
      end else begin
        r_rdata <= r_mem[addr];
      end
    end
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/esp_storage_responder.sv
`default_nettype none
// ============================================================================
// Module      : esp_storage_responder
// Description : Far-end emulation of the ESP storage agent on the 28-bit
//               tri-state command bus. Announces with the init word until the
//               first command, then listens, serves READ/WRITE/PING from a
//               256x8 store and drives tagged responses.
// Ports       : clk         - system clock
//               reset       - synchronous active-high reset
//               enable      - low freezes state/counters and releases bus
//               esp_cmd     - shared command bus (inout)
//               bus_drive   - registered output enable of esp_cmd
//               cmd_count   - commands served since reset (wraps)
//               overrun     - sticky, command seen while busy
//               debug_state - current FSM state encoding
// Revision    : 1.0 - initial release
// ============================================================================
module esp_storage_responder
  import esp_storage_responder_pkg::*;
#(
  parameter int         ANNOUNCE_CYCLES = 4,
  parameter int         ANNOUNCE_GAP    = 4,
  parameter int         TURNAROUND      = 1,   // must be >= 1 so rdata is ready
  parameter int         RESP_HOLD       = 2,
  parameter logic [7:0] PING_VALUE      = 8'hA5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  inout  wire  [27:0] esp_cmd,
  output logic        bus_drive,
  output logic [15:0] cmd_count,
  output logic        overrun,
  output logic [2:0]  debug_state
);

  localparam logic [7:0] C_ANN_LAST  = 8'(ANNOUNCE_CYCLES - 1);
  localparam logic [7:0] C_GAP_LAST  = 8'(ANNOUNCE_GAP - 1);
  localparam logic [7:0] C_TURN_LAST = 8'(TURNAROUND - 1);
  localparam logic [7:0] C_HOLD_LAST = 8'(RESP_HOLD - 1);

  esp_state_t  r_state, w_state_nxt;
  logic [7:0]  r_cnt, w_cnt_nxt;
  logic        r_bus_drive;
  logic [15:0] r_cmd_count;
  logic        r_overrun;
  esp_cap_t    r_cap;
  logic [27:0] r_resp;

  logic        w_cmd_valid;
  logic        w_capture;
  logic        w_overrun_set;
  logic        w_count_inc;
  logic        w_mem_en;
  logic [7:0]  w_rdata;
  logic [7:0]  w_resp_data;
  logic [27:0] w_drive_word;

  // Only look at the bus while we are not driving it ourselves
  assign w_cmd_valid = !r_bus_drive && !esp_cmd[27] && (esp_cmd[26:24] != C_OP_INIT);

  // Drive-state hold counters advance only on cycles the word was actually
  // on the bus, so a disable/re-enable resumes with the remaining count.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_capture     = 1'b0;
    w_overrun_set = 1'b0;
    w_count_inc   = 1'b0;
    case (r_state)
      ST_ANNOUNCE: begin
        if (r_bus_drive) begin
          if (r_cnt == C_ANN_LAST) begin
            w_state_nxt = ST_ANN_GAP;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      ST_ANN_GAP: begin
        if (w_cmd_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_TURN;
          w_cnt_nxt   = 8'd0;
        end else if (r_cnt == C_GAP_LAST) begin
          w_state_nxt = ST_ANNOUNCE;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_LISTEN: begin
        if (w_cmd_valid) begin
          w_capture   = 1'b1;
          w_state_nxt = ST_TURN;
          w_cnt_nxt   = 8'd0;
        end
      end
      ST_TURN: begin
        w_overrun_set = w_cmd_valid;
        if (r_cnt == C_TURN_LAST) begin
          w_state_nxt = ST_RESPOND;
          w_cnt_nxt   = 8'd0;
          w_count_inc = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 8'd1;
        end
      end
      ST_RESPOND: begin
        if (r_bus_drive) begin
          if (r_cnt == C_HOLD_LAST) begin
            w_state_nxt = ST_LISTEN;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
      end
      default: begin
        w_state_nxt = ST_ANNOUNCE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_ANNOUNCE;
      r_cnt       <= 8'd0;
      r_bus_drive <= 1'b0;
      r_cmd_count <= 16'd0;
      r_overrun   <= 1'b0;
    end else if (enable) begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_bus_drive <= (w_state_nxt == ST_ANNOUNCE) || (w_state_nxt == ST_RESPOND);
      if (w_count_inc) begin
        r_cmd_count <= r_cmd_count + 16'd1;
      end
      if (w_overrun_set) begin
        r_overrun <= 1'b1;
      end
    end else begin
      r_bus_drive <= 1'b0;
    end
  end

  // Store access happens on the capture edge; write-first makes rdata carry
  // the written byte for WRITE, which is exactly the response data.
  assign w_mem_en = w_capture && enable && !reset;

  esp_storage_responder_mem u_mem (
    .clk   (clk),
    .en    (w_mem_en),
    .we    (esp_cmd[26:24] == C_OP_WRITE),
    .addr  (esp_cmd[15:8]),
    .wdata (esp_cmd[23:16]),
    .rdata (w_rdata)
  );

  always_comb begin
    w_resp_data = 8'h00;
    case (r_cap.op)
      C_OP_READ, C_OP_WRITE: w_resp_data = w_rdata;
      C_OP_PING:             w_resp_data = PING_VALUE;
      default:               w_resp_data = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset && enable) begin
      if (w_capture) begin
        r_cap <= '{op: esp_cmd[26:24], addr: esp_cmd[15:8], tag: esp_cmd[7:0]};
      end
      if (w_count_inc) begin
        r_resp <= {1'b1, esp_resp_op(r_cap.op), w_resp_data, r_cap.addr, r_cap.tag};
      end
    end
  end

  // bus_drive is only ever set in ANNOUNCE or RESPOND; word comes from registers
  assign w_drive_word = (r_state == ST_ANNOUNCE) ? C_INIT_WORD : r_resp;
  assign esp_cmd      = r_bus_drive ? w_drive_word : 28'bz;

  assign bus_drive   = r_bus_drive;
  assign cmd_count   = r_cmd_count;
  assign overrun     = r_overrun;
  assign debug_state = r_state;

endmodule
`default_nettype wire
